// File: rtl/ahb_rr_arbiter_2m1s_pkg.sv
// ----------------------------------------------------------------------------
// ahb_rr_arbiter_2m1s_pkg
// Shared definitions for the two-master AHB-Lite round-robin arbiter:
// HTRANS encodings, the data-phase owner enum and small HTRANS helpers.
// No ports (package).
// ----------------------------------------------------------------------------
package ahb_rr_arbiter_2m1s_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_M0   = 2'd1,
    OWNER_M1   = 2'd2
  } owner_e;

  // NONSEQ and SEQ both carry a real transfer (bit 1 set).
  function automatic logic is_active(input logic [1:0] trans);
    return trans[1];
  endfunction

  // SEQ and BUSY mean the master is still inside a burst.
  function automatic logic is_burst_cont(input logic [1:0] trans);
    return (trans == HTRANS_SEQ) || (trans == HTRANS_BUSY);
  endfunction

endpackage

// File: rtl/ahb_rr_arbiter_2m1s_hold_stage.sv
// ----------------------------------------------------------------------------
// ahb_rr_arbiter_2m1s_hold_stage
// One-entry address-phase holding stage for a single master. A live request
// that is not granted is captured so the master only stalls in its own data
// phase; the held copy is then presented until it wins.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   haddr/htrans/hwrite/hsize       live master address phase
//   hready_m                        ready currently returned to this master
//   grant                           this master wins arbitration this cycle
//   req                             pending or live request
//   pend                            a held transfer is waiting
//   out_addr/trans/write/size       held copy if pending, else live inputs
// ----------------------------------------------------------------------------
module ahb_rr_arbiter_2m1s_hold_stage
  import ahb_rr_arbiter_2m1s_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic          hready_m,
  input  logic          grant,
  output logic          req,
  output logic          pend,
  output logic [AW-1:0] out_addr,
  output logic [1:0]    out_trans,
  output logic          out_write,
  output logic [2:0]    out_size
);

  logic          live_req;
  logic [AW-1:0] hold_addr;
  logic [1:0]    hold_trans;
  logic          hold_write;
  logic [2:0]    hold_size;

  // The master only launches an address phase when its ready is high.
  assign live_req = is_active(htrans) & hready_m;
  assign req      = pend | live_req;

  // A held entry is never overwritten; a grant retires it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= 1'b0;
      hold_addr  <= '0;
      hold_trans <= HTRANS_IDLE;
      hold_write <= 1'b0;
      hold_size  <= '0;
    end else if (grant) begin
      pend <= 1'b0;
    end else if (live_req && !pend) begin
      pend       <= 1'b1;
      hold_addr  <= haddr;
      hold_trans <= htrans;
      hold_write <= hwrite;
      hold_size  <= hsize;
    end
  end

  assign out_addr  = pend ? hold_addr  : haddr;
  assign out_trans = pend ? hold_trans : htrans;
  assign out_write = pend ? hold_write : hwrite;
  assign out_size  = pend ? hold_size  : hsize;

endmodule

// File: rtl/ahb_rr_arbiter_2m1s.sv
// ----------------------------------------------------------------------------
// ahb_rr_arbiter_2m1s
// Round-robin AHB-Lite arbiter joining two masters (M0 = IFU, M1 = LSU) onto
// one slave bus, with per-master address holding stages, burst locking and
// data-phase ownership for HREADY/HRESP/HWDATA routing.
// Ports:
//   HCLK, HRESETn                   clock, async active-low reset
//   HADDR/HTRANS/HWRITE/HSIZE_Mx    master address phase (x = 0,1)
//   HWDATA_Mx                       master write data
//   HREADY_Mx, HRESP_Mx, HRDATA_Mx  responses returned to master x
//   HADDR/HTRANS/HWRITE/HSIZE       slave address phase
//   HWDATA                          slave write data
//   HREADY, HRESP, HRDATA           slave responses
// ----------------------------------------------------------------------------
module ahb_rr_arbiter_2m1s
  import ahb_rr_arbiter_2m1s_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 64,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [AW-1:0] HADDR_M0,
  input  logic [1:0]    HTRANS_M0,
  input  logic          HWRITE_M0,
  input  logic [2:0]    HSIZE_M0,
  input  logic [DW-1:0] HWDATA_M0,
  output logic          HREADY_M0,
  output logic          HRESP_M0,
  output logic [DW-1:0] HRDATA_M0,
  input  logic [AW-1:0] HADDR_M1,
  input  logic [1:0]    HTRANS_M1,
  input  logic          HWRITE_M1,
  input  logic [2:0]    HSIZE_M1,
  input  logic [DW-1:0] HWDATA_M1,
  output logic          HREADY_M1,
  output logic          HRESP_M1,
  output logic [DW-1:0] HRDATA_M1,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [DW-1:0] HWDATA,
  input  logic          HREADY,
  input  logic          HRESP,
  input  logic [DW-1:0] HRDATA
);

  owner_e        dp_owner;
  owner_e        last_grant;
  owner_e        lock_owner;
  owner_e        winner;
  logic          lock;
  logic          lock_active;
  logic          arb_en;
  logic          req0, req1, pend0, pend1;
  logic [AW-1:0] addr0, addr1;
  logic [1:0]    trans0, trans1;
  logic          write0, write1;
  logic [2:0]    size0, size1;

  ahb_rr_arbiter_2m1s_hold_stage #(.AW(AW)) u_hold_m0 (
    .clk(HCLK), .rst_n(HRESETn),
    .haddr(HADDR_M0), .htrans(HTRANS_M0), .hwrite(HWRITE_M0), .hsize(HSIZE_M0),
    .hready_m(HREADY_M0), .grant(winner == OWNER_M0),
    .req(req0), .pend(pend0),
    .out_addr(addr0), .out_trans(trans0), .out_write(write0), .out_size(size0)
  );

  ahb_rr_arbiter_2m1s_hold_stage #(.AW(AW)) u_hold_m1 (
    .clk(HCLK), .rst_n(HRESETn),
    .haddr(HADDR_M1), .htrans(HTRANS_M1), .hwrite(HWRITE_M1), .hsize(HSIZE_M1),
    .hready_m(HREADY_M1), .grant(winner == OWNER_M1),
    .req(req1), .pend(pend1),
    .out_addr(addr1), .out_trans(trans1), .out_write(write1), .out_size(size1)
  );

  // The lock only holds while the owner keeps signalling SEQ/BUSY; an IDLE
  // or a fresh NONSEQ from it releases the bus in the same cycle.
  assign lock_active = lock &
    (((lock_owner == OWNER_M0) && is_burst_cont(HTRANS_M0)) ||
     ((lock_owner == OWNER_M1) && is_burst_cont(HTRANS_M1)));

  // No grant changes during an error response; the pending master waits
  // until the slave is back to a normal ready cycle.
  assign arb_en = HREADY & ~HRESP;

  always_comb begin
    winner = OWNER_NONE;
    if (arb_en) begin
      if (lock_active)          winner = lock_owner;
      else if (req0 && req1)    winner = (FIXED_PRI || last_grant == OWNER_M1) ? OWNER_M0 : OWNER_M1;
      else if (req0)            winner = OWNER_M0;
      else if (req1)            winner = OWNER_M1;
    end
  end

  always_comb begin
    HADDR  = '0;
    HTRANS = HTRANS_IDLE;
    HWRITE = 1'b0;
    HSIZE  = '0;
    case (winner)
      OWNER_M0: begin HADDR = addr0; HTRANS = trans0; HWRITE = write0; HSIZE = size0; end
      OWNER_M1: begin HADDR = addr1; HTRANS = trans1; HWRITE = write1; HSIZE = size1; end
      default:  ;
    endcase
  end

  // A BUSY beat keeps the current data-phase owner.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_owner   <= OWNER_NONE;
      last_grant <= OWNER_M1;
      lock       <= 1'b0;
      lock_owner <= OWNER_NONE;
    end else if (HREADY) begin
      if (winner != OWNER_NONE) begin
        if (HTRANS != HTRANS_BUSY) dp_owner <= winner;
        last_grant <= winner;
        lock       <= is_active(HTRANS) | lock_active;
        lock_owner <= winner;
      end else begin
        dp_owner <= OWNER_NONE;
        lock     <= 1'b0;
      end
    end
  end

  // A master with no data phase in flight sees zero-wait OKAY unless its
  // address phase is parked in the holding stage.
  assign HREADY_M0 = (dp_owner == OWNER_M0) ? HREADY : ~pend0;
  assign HREADY_M1 = (dp_owner == OWNER_M1) ? HREADY : ~pend1;
  assign HRESP_M0  = (dp_owner == OWNER_M0) & HRESP;
  assign HRESP_M1  = (dp_owner == OWNER_M1) & HRESP;
  assign HRDATA_M0 = HRDATA;
  assign HRDATA_M1 = HRDATA;

  always_comb begin
    HWDATA = '0;
    case (dp_owner)
      OWNER_M0: HWDATA = HWDATA_M0;
      OWNER_M1: HWDATA = HWDATA_M1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_ahb_rr_arbiter_2m1s.sv
// ----------------------------------------------------------------------------
// tb_ahb_rr_arbiter_2m1s
// Directed self-checking bench for ahb_rr_arbiter_2m1s. A round-robin and a
// fixed-priority instance share the master/slave inputs.
// ----------------------------------------------------------------------------
module tb_ahb_rr_arbiter_2m1s;
  import ahb_rr_arbiter_2m1s_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic [AW-1:0] haddr_m0, haddr_m1;
  logic [1:0]    htrans_m0, htrans_m1;
  logic          hwrite_m0, hwrite_m1;
  logic [2:0]    hsize_m0, hsize_m1;
  logic [DW-1:0] hwdata_m0, hwdata_m1;
  logic          hready, hresp;
  logic [DW-1:0] hrdata;

  logic          hready_m0, hready_m1, hresp_m0, hresp_m1;
  logic [DW-1:0] hrdata_m0, hrdata_m1;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [DW-1:0] hwdata;

  logic          fp_hready_m0, fp_hready_m1, fp_hresp_m0, fp_hresp_m1;
  logic [DW-1:0] fp_hrdata_m0, fp_hrdata_m1;
  logic [AW-1:0] fp_haddr;
  logic [1:0]    fp_htrans;
  logic          fp_hwrite;
  logic [2:0]    fp_hsize;
  logic [DW-1:0] fp_hwdata;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  ahb_rr_arbiter_2m1s #(.AW(AW), .DW(DW), .FIXED_PRI(1'b0)) dut (
    .HCLK(hclk), .HRESETn(hresetn),
    .HADDR_M0(haddr_m0), .HTRANS_M0(htrans_m0), .HWRITE_M0(hwrite_m0), .HSIZE_M0(hsize_m0),
    .HWDATA_M0(hwdata_m0), .HREADY_M0(hready_m0), .HRESP_M0(hresp_m0), .HRDATA_M0(hrdata_m0),
    .HADDR_M1(haddr_m1), .HTRANS_M1(htrans_m1), .HWRITE_M1(hwrite_m1), .HSIZE_M1(hsize_m1),
    .HWDATA_M1(hwdata_m1), .HREADY_M1(hready_m1), .HRESP_M1(hresp_m1), .HRDATA_M1(hrdata_m1),
    .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
    .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata)
  );

  ahb_rr_arbiter_2m1s #(.AW(AW), .DW(DW), .FIXED_PRI(1'b1)) dut_fp (
    .HCLK(hclk), .HRESETn(hresetn),
    .HADDR_M0(haddr_m0), .HTRANS_M0(htrans_m0), .HWRITE_M0(hwrite_m0), .HSIZE_M0(hsize_m0),
    .HWDATA_M0(hwdata_m0), .HREADY_M0(fp_hready_m0), .HRESP_M0(fp_hresp_m0), .HRDATA_M0(fp_hrdata_m0),
    .HADDR_M1(haddr_m1), .HTRANS_M1(htrans_m1), .HWRITE_M1(hwrite_m1), .HSIZE_M1(hsize_m1),
    .HWDATA_M1(hwdata_m1), .HREADY_M1(fp_hready_m1), .HRESP_M1(fp_hresp_m1), .HRDATA_M1(fp_hrdata_m1),
    .HADDR(fp_haddr), .HTRANS(fp_htrans), .HWRITE(fp_hwrite), .HSIZE(fp_hsize), .HWDATA(fp_hwdata),
    .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] t0, input logic [AW-1:0] a0, input logic w0,
                               input logic [1:0] t1, input logic [AW-1:0] a1, input logic w1);
    htrans_m0 = t0; haddr_m0 = a0; hwrite_m0 = w0; hsize_m0 = 3'd2;
    htrans_m1 = t1; haddr_m1 = a1; hwrite_m1 = w1; hsize_m1 = 3'd2;
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic nextCycle();
    @(posedge hclk);
    #1;
  endtask

  task automatic doReset();
    hresetn = 1'b0;
    applyStimulus(HTRANS_IDLE, '0, 1'b0, HTRANS_IDLE, '0, 1'b0);
    hready = 1'b1; hresp = 1'b0; hrdata = '0; hwdata_m0 = '0; hwdata_m1 = '0;
    @(posedge hclk);
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
  endtask

  // Each master issues four singles, advancing when its ready was high.
  task automatic runSingles(input bit use_fp, input logic [AW-1:0] exp_order [8], input string tag);
    int i0, i1, n;
    logic [AW-1:0] got [8];
    logic rdy0, rdy1;
    for (int k = 0; k < 8; k++) got[k] = '0;
    doReset();
    i0 = 0; i1 = 0; n = 0;
    for (int cyc = 0; cyc < 20 && n < 8; cyc++) begin
      applyStimulus((i0 < 4) ? HTRANS_NONSEQ : HTRANS_IDLE, AW'(4 * i0), 1'b0,
                    (i1 < 4) ? HTRANS_NONSEQ : HTRANS_IDLE, AW'(32'h1000 + 4 * i1), 1'b1);
      #3;
      rdy0 = use_fp ? fp_hready_m0 : hready_m0;
      rdy1 = use_fp ? fp_hready_m1 : hready_m1;
      if ((use_fp ? fp_htrans : htrans) == HTRANS_NONSEQ) begin
        got[n] = use_fp ? fp_haddr : haddr;
        n++;
      end
      if (rdy0 && i0 < 4) i0++;
      if (rdy1 && i1 < 4) i1++;
      nextCycle();
    end
    checkOutput({tag, "_count"}, 64'(n), 64'd8);
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("%s_%0d", tag, k), 64'(got[k]), 64'(exp_order[k]));
  endtask

  logic [AW-1:0] rr_order [8];
  logic [AW-1:0] fp_order [8];

  initial begin
    rr_order = '{32'h0, 32'h1000, 32'h4, 32'h1004, 32'h8, 32'h1008, 32'hC, 32'h100C};
    fp_order = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h1000, 32'h1004, 32'h1008, 32'h100C};

    // Reset values
    hresetn = 1'b0;
    applyStimulus(HTRANS_IDLE, '0, 1'b0, HTRANS_IDLE, '0, 1'b0);
    hready = 1'b1; hresp = 1'b0; hrdata = '0; hwdata_m0 = 64'h55; hwdata_m1 = 64'h66;
    #3;
    checkOutput("rst_hready_m0", 64'(hready_m0), 64'd1);
    checkOutput("rst_hready_m1", 64'(hready_m1), 64'd1);
    checkOutput("rst_hresp_m0", 64'(hresp_m0), 64'd0);
    checkOutput("rst_htrans", 64'(htrans), 64'(HTRANS_IDLE));
    checkOutput("rst_hwdata", hwdata, 64'd0);

    // 1: single read with zero-latency bypass
    doReset();
    applyStimulus(HTRANS_NONSEQ, 32'h100, 1'b0, HTRANS_IDLE, '0, 1'b0);
    #3;
    checkOutput("t1_haddr", 64'(haddr), 64'h100);
    checkOutput("t1_htrans", 64'(htrans), 64'(HTRANS_NONSEQ));
    checkOutput("t1_hready_m0", 64'(hready_m0), 64'd1);
    nextCycle();
    applyStimulus(HTRANS_IDLE, '0, 1'b0, HTRANS_IDLE, '0, 1'b0);
    hrdata = 64'h1122334455667788;
    #3;
    checkOutput("t1_hrdata_m0", hrdata_m0, 64'h1122334455667788);
    checkOutput("t1_dp_hready_m0", 64'(hready_m0), 64'd1);

    // 2: simultaneous requests, M0 wins first tie, M1 held
    doReset();
    applyStimulus(HTRANS_NONSEQ, 32'h100, 1'b0, HTRANS_NONSEQ, 32'h2000, 1'b1);
    #3;
    checkOutput("t2_c0_haddr", 64'(haddr), 64'h100);
    checkOutput("t2_c0_hwrite", 64'(hwrite), 64'd0);
    nextCycle();
    applyStimulus(HTRANS_IDLE, '0, 1'b0, HTRANS_IDLE, '0, 1'b0);
    hwdata_m1 = 64'hCAFE0000BEEF;
    #3;
    checkOutput("t2_c1_hready_m1", 64'(hready_m1), 64'd0);
    checkOutput("t2_c1_haddr", 64'(haddr), 64'h2000);
    checkOutput("t2_c1_hwrite", 64'(hwrite), 64'd1);
    nextCycle();
    #3;
    checkOutput("t2_c2_hwdata", hwdata, 64'hCAFE0000BEEF);
    checkOutput("t2_c2_hready_m1", 64'(hready_m1), 64'd1);

    // 3: back-to-back singles
    runSingles(1'b0, rr_order, "t3_rr");
    runSingles(1'b1, fp_order, "t3_fp");

    // 4: INCR4 burst locks out M1 until after the last beat
    doReset();
    applyStimulus(HTRANS_NONSEQ, 32'h40, 1'b0, HTRANS_IDLE, '0, 1'b0);
    #3; checkOutput("t4_b0_haddr", 64'(haddr), 64'h40);
    nextCycle();
    applyStimulus(HTRANS_SEQ, 32'h44, 1'b0, HTRANS_IDLE, '0, 1'b0);
    #3; checkOutput("t4_b1_haddr", 64'(haddr), 64'h44);
    nextCycle();
    applyStimulus(HTRANS_SEQ, 32'h48, 1'b0, HTRANS_NONSEQ, 32'h3000, 1'b0);
    #3;
    checkOutput("t4_b2_haddr", 64'(haddr), 64'h48);
    checkOutput("t4_b2_hready_m1", 64'(hready_m1), 64'd1);
    nextCycle();
    applyStimulus(HTRANS_SEQ, 32'h4C, 1'b0, HTRANS_IDLE, '0, 1'b0);
    #3;
    checkOutput("t4_b3_haddr", 64'(haddr), 64'h4C);
    checkOutput("t4_b3_htrans", 64'(htrans), 64'(HTRANS_SEQ));
    checkOutput("t4_b3_hready_m1", 64'(hready_m1), 64'd0);
    nextCycle();
    applyStimulus(HTRANS_IDLE, '0, 1'b0, HTRANS_IDLE, '0, 1'b0);
    #3;
    checkOutput("t4_m1_haddr", 64'(haddr), 64'h3000);
    checkOutput("t4_m1_htrans", 64'(htrans), 64'(HTRANS_NONSEQ));

    // 5: slave wait states on M1 data phase, M0 parked then issued
    doReset();
    applyStimulus(HTRANS_IDLE, '0, 1'b0, HTRANS_NONSEQ, 32'h500, 1'b0);
    #3; checkOutput("t5_c0_haddr", 64'(haddr), 64'h500);
    nextCycle();
    applyStimulus(HTRANS_NONSEQ, 32'h80, 1'b0, HTRANS_IDLE, '0, 1'b0);
    hready = 1'b0;
    #3; checkOutput("t5_c1_htrans", 64'(htrans), 64'(HTRANS_IDLE));
    nextCycle();
    applyStimulus(HTRANS_IDLE, '0, 1'b0, HTRANS_IDLE, '0, 1'b0);
    #3;
    checkOutput("t5_c2_hready_m0", 64'(hready_m0), 64'd0);
    checkOutput("t5_c2_hready_m1", 64'(hready_m1), 64'd0);
    nextCycle();
    nextCycle();
    hready = 1'b1;
    #3;
    checkOutput("t5_c4_haddr", 64'(haddr), 64'h80);
    checkOutput("t5_c4_htrans", 64'(htrans), 64'(HTRANS_NONSEQ));
    checkOutput("t5_c4_hready_m1", 64'(hready_m1), 64'd1);
    checkOutput("t5_c4_hready_m0", 64'(hready_m0), 64'd0);

    // 6: two-cycle ERROR to M1, then reset while M0 is pending
    doReset();
    applyStimulus(HTRANS_IDLE, '0, 1'b0, HTRANS_NONSEQ, 32'h600, 1'b1);
    nextCycle();
    applyStimulus(HTRANS_NONSEQ, 32'h90, 1'b0, HTRANS_IDLE, '0, 1'b0);
    hready = 1'b0; hresp = 1'b1;
    #3;
    checkOutput("t6_e1_hresp_m1", 64'(hresp_m1), 64'd1);
    checkOutput("t6_e1_hready_m1", 64'(hready_m1), 64'd0);
    checkOutput("t6_e1_hresp_m0", 64'(hresp_m0), 64'd0);
    nextCycle();
    applyStimulus(HTRANS_IDLE, '0, 1'b0, HTRANS_IDLE, '0, 1'b0);
    hready = 1'b1;
    #3;
    checkOutput("t6_e2_hresp_m1", 64'(hresp_m1), 64'd1);
    checkOutput("t6_e2_hready_m1", 64'(hready_m1), 64'd1);
    checkOutput("t6_e2_hresp_m0", 64'(hresp_m0), 64'd0);
    checkOutput("t6_e2_hready_m0", 64'(hready_m0), 64'd0);
    hresetn = 1'b0;
    #1;
    checkOutput("t6_rst_htrans", 64'(htrans), 64'(HTRANS_IDLE));
    checkOutput("t6_rst_hready_m0", 64'(hready_m0), 64'd1);
    nextCycle();
    hresetn = 1'b1; hresp = 1'b0;
    #3;
    checkOutput("t6_post_htrans", 64'(htrans), 64'(HTRANS_IDLE));
    checkOutput("t6_post_hready_m0", 64'(hready_m0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
